// File: rtl/deadtime_multi.sv
// deadtime_multi: N-leg complementary dead-time generator.
//
// Each leg turns one PWM request bit into a high-side / low-side gate pair,
// inserting a programmable dead time (both switches off) on every edge.
// Rising and falling dead times are latched per leg on entry to the dead
// interval. Outputs are registered and pass through a per-switch polarity XOR.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   pwm_in[N_LEGS]       PWM request per leg (1 = high side on)
//   dtime_rise/fall      per-leg dead times, leg k at [k*DT_WIDTH +: DT_WIDTH]
//   logic_hi/logic_lo    per-leg output polarity (off level of each switch)
//   pwm_en               global enable, 0 forces every switch to its off level
//   dt_en                1 = dead-time insertion, 0 = bypass (straight mapping)
//   pwm_hi/pwm_lo        registered gate outputs
//   dt_busy              leg is inside a dead interval
//
// Optional build macro DEADTIME_MULTI_MINON_EN: adds a per-leg minimum
// on-time hold of MIN_ON cycles on each on-state.
module deadtime_multi #(
  parameter int N_LEGS   = 3,
  parameter int DT_WIDTH = 10,
  parameter int MIN_ON   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_LEGS-1:0]            pwm_in,
  input  logic [N_LEGS*DT_WIDTH-1:0]   dtime_rise,
  input  logic [N_LEGS*DT_WIDTH-1:0]   dtime_fall,
  input  logic [N_LEGS-1:0]            logic_hi,
  input  logic [N_LEGS-1:0]            logic_lo,
  input  logic                         pwm_en,
  input  logic                         dt_en,
  output logic [N_LEGS-1:0]            pwm_hi,
  output logic [N_LEGS-1:0]            pwm_lo,
  output logic [N_LEGS-1:0]            dt_busy
);

  typedef enum logic [1:0] {S_LO_ON, S_DT_RISE, S_HI_ON, S_DT_FALL} state_t;

  logic [N_LEGS-1:0] hi, lo;

`ifndef DEADTIME_MULTI_MINON_EN
  logic [31:0] unused_min_on;
  assign unused_min_on = MIN_ON;
`endif

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    state_t              state, state_nxt;
    logic [DT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc, lim, lim_nxt, rise, fall;
    logic                pin, hold_ok;

    assign pin     = pwm_in[k];
    assign rise    = dtime_rise[k*DT_WIDTH +: DT_WIDTH];
    assign fall    = dtime_fall[k*DT_WIDTH +: DT_WIDTH];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + DT_WIDTH'(1);  // saturate, no wrap

`ifdef DEADTIME_MULTI_MINON_EN
    localparam int HW = $clog2(MIN_ON + 2);
    logic [HW-1:0] hold, hold_nxt;

    // hold <= 1 means it reaches 0 at this edge, giving exactly MIN_ON
    // cycles in the on-state before an exit is allowed.
    assign hold_ok = (hold <= HW'(1));

    always_comb begin
      hold_nxt = (hold != '0) ? hold - HW'(1) : hold;
      if (!dt_en)
        hold_nxt = '0;
      else if (state_nxt != state && (state_nxt == S_HI_ON || state_nxt == S_LO_ON))
        hold_nxt = HW'(MIN_ON);
    end

    always_ff @(posedge clk) begin
      if (reset) hold <= '0;
      else       hold <= hold_nxt;
    end
`else
    assign hold_ok = 1'b1;
`endif

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lim_nxt   = lim;
      if (!dt_en) begin
        // bypass: state tracks the request directly
        state_nxt = pin ? S_HI_ON : S_LO_ON;
        cnt_nxt   = '0;
      end else begin
        case (state)
          S_LO_ON: begin
            if (pin && hold_ok) begin
              state_nxt = S_DT_RISE;
              cnt_nxt   = DT_WIDTH'(1);
              lim_nxt   = rise;
            end
          end
          S_DT_RISE: begin
            // abort outranks expiry
            if (!pin) begin
              if (hold_ok) begin
                state_nxt = S_LO_ON;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else if (cnt >= lim) begin
              state_nxt = S_HI_ON;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
          S_HI_ON: begin
            if (!pin && hold_ok) begin
              state_nxt = S_DT_FALL;
              cnt_nxt   = DT_WIDTH'(1);
              lim_nxt   = fall;
            end
          end
          S_DT_FALL: begin
            if (pin) begin
              if (hold_ok) begin
                state_nxt = S_HI_ON;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else if (cnt >= lim) begin
              state_nxt = S_LO_ON;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
          default: begin
            state_nxt = S_LO_ON;
            cnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= S_LO_ON;
        cnt   <= '0;
        lim   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        lim   <= lim_nxt;
      end
    end

    // hi/lo come straight from a one-hot subset of states, so they can never overlap
    assign hi[k]      = (state == S_HI_ON) & ~reset;
    assign lo[k]      = (state == S_LO_ON) & ~reset;
    assign dt_busy[k] = (state == S_DT_RISE || state == S_DT_FALL) & dt_en & ~reset;
  end

  always_ff @(posedge clk) begin
    pwm_hi <= (hi & {N_LEGS{pwm_en}}) ^ logic_hi;
    pwm_lo <= (lo & {N_LEGS{pwm_en}}) ^ logic_lo;
  end

endmodule

// File: doc/deadtime_multi.md
Name: deadtime_multi

Overview:
- Parametrised N-leg complementary dead-time generator; successor to the single-channel dead-time block.
- Each leg takes one carrier-comparator PWM bit and produces a high-side/low-side gate pair.
- Rising and falling dead times are independently programmable per leg; output polarity is per switch.
- Sits between the PWM comparator stage and the gate-driver pins, with configuration from AXI4-Lite registers.

Parameters:
- N_LEGS, 3, number of independent legs.
- DT_WIDTH, 10, width of each dead-time value and its counter.
- MIN_ON, 4, minimum on-time in clk cycles (used only when the optional feature is compiled in).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  N_LEGS  raw PWM request per leg; 1 = high side on.
- dtime_rise  in  N_LEGS*DT_WIDTH  per-leg dead time before high side turns on; leg k in bits [k*DT_WIDTH +: DT_WIDTH].
- dtime_fall  in  N_LEGS*DT_WIDTH  per-leg dead time before low side turns on; same packing.
- logic_hi  in  N_LEGS  polarity XOR applied to the high-side output.
- logic_lo  in  N_LEGS  polarity XOR applied to the low-side output.
- pwm_en  in  1  global enable; 0 forces all switches off.
- dt_en  in  1  1 = dead-time insertion active; 0 = bypass.
- pwm_hi  out  N_LEGS  high-side gate, registered.
- pwm_lo  out  N_LEGS  low-side gate, registered.
- dt_busy  out  N_LEGS  1 while the leg is in a dead-time state.

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock and reset ports are named clk and reset.
- Per-leg FSM states: S_LO_ON, S_DT_RISE, S_HI_ON, S_DT_FALL. Reset state is S_LO_ON with counter = 0.
- On reset, internal (pre-polarity) hi = 0, lo = 0, and dt_busy = 0.
- Transitions:
  - S_LO_ON: pwm_in=1 -> S_DT_RISE.
  - S_DT_RISE: pwm_in=0 -> S_LO_ON (abort; low side resumes with no added dead time). Otherwise, counter >= latched rise value -> S_HI_ON.
  - S_HI_ON: pwm_in=0 -> S_DT_FALL.
  - S_DT_FALL: pwm_in=1 -> S_HI_ON (abort). Otherwise, counter >= latched fall value -> S_LO_ON.
- Abort has priority over counter expiry when both occur in the same cycle.
- Dead-time value handling:
  - The dead-time value is latched on entry to a DT state. Changes to dtime_* mid-interval take effect on the next interval.
  - The counter loads 1 on DT entry and increments by 1 per cycle while in the DT state.
  - Effective dead time is max(dtime,1) cycles with both switches off.
  - The counter saturates at all-ones; there is no wrap.
- Internal outputs:
  - hi = 1 only in S_HI_ON.
  - lo = 1 only in S_LO_ON, except that lo = 0 while in reset.
  - dt_busy = 1 in both DT states.
- Output mapping:
  - pwm_hi = (hi & pwm_en) ^ logic_hi.
  - pwm_lo = (lo & pwm_en) ^ logic_lo.
  - Both are registered, giving 1-cycle latency from the state update.
  - pwm_in edge to first output change = 2 clk cycles.
- Bypass (dt_en=0):
  - The FSM is forced each cycle to S_HI_ON if pwm_in=1, else S_LO_ON. The counter is cleared.
  - hi = pwm_in and lo = ~pwm_in, still registered, so latency is unchanged.
  - dt_busy = 0.
- dt_en 0->1: resumes from the forced state; no glitch.
- pwm_en=0:
  - Both outputs are held at their off level (logic_hi / logic_lo).
  - The FSM keeps tracking pwm_in, so re-enable is immediate with no dead-time replay.
- Invariant: hi and lo are never both 1 in any cycle (pre-polarity), in every mode.
- Legs are fully independent. The logic is generate-replicated per leg.

Optional Feature:
- Macro: DEADTIME_MULTI_MINON_EN.
- Defined:
  - On entry to S_HI_ON or S_LO_ON, a per-leg hold counter loads MIN_ON.
  - The exit transition, and the DT-state abort back into that same on-state, are blocked until the hold reaches 0.
  - A pending request is honoured after the hold expires only if pwm_in is still at the new level; otherwise the edge is dropped.
  - Bypass mode ignores the hold.
- Undefined: no hold logic is built; behaviour is exactly as above.

Test Plan:
- Reset, then pwm_in[0]: 0->1 with dtime_rise=5, dt_en=1, pwm_en=1, polarity 0 -> pwm_lo[0] falls 2 cycles after the edge; pwm_hi[0] rises exactly 5 cycles later; dt_busy[0] high for 5 cycles.
- 1->0 edge with dtime_fall=3 and dtime_fall=0 -> low side turns on after 3 dead cycles and 1 dead cycle respectively; hi/lo never overlap.
- pwm_in pulses high for 2 cycles with dtime_rise=6 -> S_DT_RISE aborts; pwm_hi stays 0; pwm_lo returns after a 2-cycle gap.
- dt_en=0, toggle pwm_in each cycle -> pwm_hi mirrors pwm_in and pwm_lo mirrors ~pwm_in, both at 2-cycle latency; dt_busy=0.
- pwm_en=0 with logic_hi=1, logic_lo=0 -> pwm_hi=1 and pwm_lo=0 constantly. Assert reset mid-S_DT_RISE -> next cycle is S_LO_ON with counter 0.
- With DEADTIME_MULTI_MINON_EN, MIN_ON=4: pwm_in high 1 cycle after dead time expires -> pwm_hi held 4 cycles, then S_DT_FALL follows. Run 3 legs with distinct dead times concurrently -> each leg meets its own timing.
